han_fan_i2c_arbiter: RTL and testbench

HAN_FAN_I2C_ARBITER -- requirements
Module: han_fan_i2c_arbiter

---
 rtl/han_fan_i2c_arbiter.sv | 158 +++++++++++++++
 tb/tb_han_fan_i2c_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/han_fan_i2c_arbiter.sv
// Two-requester round-robin arbiter in front of an I2C byte engine.
// Adds a per-transaction timeout and a bus-free gap after every transaction.
module han_fan_i2c_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter int unsigned GAP_CYCLES     = 250
) (
  input  logic        clk_50Mhz,
  input  logic        reset_n,
  input  logic [1:0]  req,
  input  logic [1:0]  req_rnw,
  input  logic [13:0] req_dev,
  input  logic [15:0] req_reg,
  input  logic [15:0] req_wdata,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        eng_start,
  output logic        eng_rnw,
  output logic [6:0]  eng_dev,
  output logic [7:0]  eng_reg,
  output logic [7:0]  eng_wdata,
  output logic        eng_abort,
  input  logic        eng_done,
  input  logic        eng_err,
  input  logic [7:0]  eng_rdata
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] ToLast = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GapLast = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StGap} state_e;

  state_e          state_q, state_d;
  logic            winner_q, winner_d;
  logic            last_q, last_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [1:0]      done_q, done_d;
  logic            err_q, err_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            rnw_q, rnw_d;
  logic [6:0]      dev_q, dev_d;
  logic [7:0]      reg_q, reg_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            sel;

  // Under contention the requester not served last wins.
  assign sel = (req == 2'b11) ? ~last_q : req[1];

  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    last_d    = last_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 2'b00;
    err_d     = err_q;
    rdata_d   = rdata_q;
    rnw_d     = rnw_q;
    dev_d     = dev_q;
    reg_d     = reg_q;
    wdata_d   = wdata_q;
    eng_abort = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          winner_d = sel;
          rnw_d    = req_rnw[sel];
          dev_d    = sel ? req_dev[13:7] : req_dev[6:0];
          reg_d    = sel ? req_reg[15:8] : req_reg[7:0];
          wdata_d  = sel ? req_wdata[15:8] : req_wdata[7:0];
          state_d  = StIssue;
        end
      end
      StIssue: begin
        to_cnt_d = '0;
        state_d  = StWait;
      end
      StWait: begin
        if (eng_done) begin
          done_d[winner_q] = 1'b1;
          err_d            = eng_err;
          rdata_d          = eng_rdata;
          last_d           = winner_q;
          gap_cnt_d        = '0;
          state_d          = StGap;
        end else if (to_cnt_q == ToLast) begin
          // Abort the engine now; the failed completion is reported next cycle.
          eng_abort        = 1'b1;
          done_d[winner_q] = 1'b1;
          err_d            = 1'b1;
          rdata_d          = 8'h00;
          last_d           = winner_q;
          gap_cnt_d        = '0;
          state_d          = StGap;
        end else if (to_cnt_q != '1) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_cnt_q >= GapLast) begin
          state_d = StIdle;
        end else if (gap_cnt_q != '1) begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      winner_q  <= 1'b0;
      last_q    <= 1'b1;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
      done_q    <= 2'b00;
      err_q     <= 1'b0;
      rdata_q   <= 8'h00;
      rnw_q     <= 1'b0;
      dev_q     <= 7'h00;
      reg_q     <= 8'h00;
      wdata_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      last_q    <= last_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      rnw_q     <= rnw_d;
      dev_q     <= dev_d;
      reg_q     <= reg_d;
      wdata_q   <= wdata_d;
    end
  end

  assign gnt       = (state_q == StIssue || state_q == StWait) ?
                     (winner_q ? 2'b10 : 2'b01) : 2'b00;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q != StIdle);
  assign eng_start = (state_q == StIssue);
  assign eng_rnw   = rnw_q;
  assign eng_dev   = dev_q;
  assign eng_reg   = reg_q;
  assign eng_wdata = wdata_q;

endmodule

// File: tb/tb_han_fan_i2c_arbiter.sv
// Randomized transaction-level bench for han_fan_i2c_arbiter against a
// round-robin / timing reference model.
module tb_han_fan_i2c_arbiter;

  localparam int T = 100;
  localparam int G = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  req_rnw = '0;
  logic [13:0] req_dev = '0;
  logic [15:0] req_reg = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  gnt, done;
  logic        err, busy, eng_start, eng_rnw, eng_abort;
  logic [7:0]  rdata, eng_reg, eng_wdata;
  logic [6:0]  eng_dev;
  logic        eng_done = 1'b0;
  logic        eng_err = 1'b0;
  logic [7:0]  eng_rdata = '0;

  han_fan_i2c_arbiter #(
    .TIMEOUT_CYCLES(T),
    .GAP_CYCLES    (G)
  ) dut (
    .clk_50Mhz(clk),
    .reset_n  (reset_n),
    .req      (req),
    .req_rnw  (req_rnw),
    .req_dev  (req_dev),
    .req_reg  (req_reg),
    .req_wdata(req_wdata),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .busy     (busy),
    .eng_start(eng_start),
    .eng_rnw  (eng_rnw),
    .eng_dev  (eng_dev),
    .eng_reg  (eng_reg),
    .eng_wdata(eng_wdata),
    .eng_abort(eng_abort),
    .eng_done (eng_done),
    .eng_err  (eng_err),
    .eng_rdata(eng_rdata)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  bit         last = 1'b1;
  logic [1:0] pend = '0;
  bit         m_rnw[2];
  logic [6:0] m_dev[2];
  logic [7:0] m_reg[2];
  logic [7:0] m_wd[2];
  logic       exp_err = 1'b0;
  logic [7:0] exp_rd = '0;
  bit         use_dir = 1'b0;
  logic       dir_e;
  logic [7:0] dir_rd;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive_fields();
    req_rnw   = {m_rnw[1], m_rnw[0]};
    req_dev   = {m_dev[1], m_dev[0]};
    req_reg   = {m_reg[1], m_reg[0]};
    req_wdata = {m_wd[1], m_wd[0]};
  endtask

  // mode: 0 = engine completes d cycles after start, 1 = timeout, 3 = reset d cycles in
  task automatic do_txn(input logic [1:0] newreq, input int mode, input int d, input bit rnd);
    logic [1:0] r, oh;
    int         w, cnt;
    bit         bad;
    logic       e;
    logic [7:0] rd;
    for (int i = 0; i < 2; i++) begin
      if (newreq[i] && !pend[i] && rnd) begin
        m_rnw[i] = 1'($urandom);
        m_dev[i] = 7'($urandom);
        m_reg[i] = 8'($urandom);
        m_wd[i]  = 8'($urandom);
      end
    end
    drive_fields();
    r   = pend | newreq;
    req = r;
    w   = (r == 2'b11) ? (last ? 0 : 1) : (r[1] ? 1 : 0);
    oh  = (w == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    check_eq("start", 64'(eng_start), 64'd1);
    check_eq("gnt_issue", 64'(gnt), 64'(oh));
    check_eq("desc", 64'({eng_rnw, eng_dev, eng_reg, eng_wdata}),
             64'({m_rnw[w], m_dev[w], m_reg[w], m_wd[w]}));
    // Granted requester withdraws; the transaction must still complete.
    r[w] = 1'b0;
    req  = r;
    pend = r;
    bad  = 1'b0;

    if (mode == 3) begin
      repeat (d) @(negedge clk);
      #2 reset_n = 1'b0;
      #1 check_eq("reset_out", 64'({gnt, done, err, rdata, busy, eng_start, eng_abort,
                                    eng_rnw, eng_dev, eng_reg, eng_wdata}), 64'd0);
      req = '0;
      pend = '0;
      last = 1'b1;
      exp_err = 1'b0;
      exp_rd = '0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (5) begin
        @(negedge clk);
        if (done != 2'b00 || busy || eng_abort) bad = 1'b1;
      end
      check_eq("post_reset_quiet", 64'(bad), 64'd0);
      return;
    end

    if (mode == 1) begin
      for (int k = 1; k < T; k++) begin
        @(negedge clk);
        if (eng_abort || eng_start || gnt != oh || done != 2'b00) bad = 1'b1;
      end
      @(negedge clk);
      check_eq("abort_pulse", 64'(eng_abort), 64'd1);
      check_eq("gnt_at_abort", 64'(gnt), 64'(oh));
      e  = 1'b1;
      rd = 8'h00;
    end else begin
      for (int k = 1; k < d; k++) begin
        @(negedge clk);
        if (eng_abort || eng_start || gnt != oh || done != 2'b00) bad = 1'b1;
      end
      @(negedge clk);
      e  = use_dir ? dir_e : 1'($urandom);
      rd = use_dir ? dir_rd : 8'($urandom);
      eng_err   = e;
      eng_rdata = rd;
      eng_done  = 1'b1;
      #1 check_eq("no_abort_on_done", 64'(eng_abort), 64'd0);
    end
    check_eq("wait_quiet", 64'(bad), 64'd0);

    @(negedge clk);
    eng_done = 1'b0;
    check_eq("done", 64'(done), 64'(oh));
    check_eq("err", 64'(err), 64'(e));
    check_eq("rdata", 64'(rdata), 64'(rd));
    check_eq("gnt_dropped", 64'({gnt, eng_abort}), 64'd0);
    last    = (w == 1);
    exp_err = e;
    exp_rd  = rd;

    // Bus-free gap: count busy cycles, inject a stray eng_done that must be ignored.
    cnt = 0;
    bad = 1'b0;
    while (busy && cnt < 1000) begin
      cnt++;
      if (gnt != 2'b00 || (cnt > 1 && done != 2'b00) || err !== exp_err || rdata !== exp_rd)
        bad = 1'b1;
      if (cnt == 2) begin
        eng_done  = 1'b1;
        eng_err   = ~exp_err;
        eng_rdata = ~exp_rd;
      end else begin
        eng_done = 1'b0;
      end
      @(negedge clk);
    end
    eng_done = 1'b0;
    check_eq("gap_len", 64'(cnt), 64'(G));
    check_eq("gap_quiet", 64'(bad), 64'd0);
  endtask

  initial begin
    logic [1:0] nr;
    int         mode, d, sel;
    @(negedge clk);
    check_eq("reset_state", 64'({gnt, done, err, rdata, busy, eng_start, eng_abort,
                                 eng_rnw, eng_dev, eng_reg, eng_wdata}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Contention from reset: 0 first, then 1, then alternation.
    do_txn(2'b11, 0, 4, 1'b1);
    do_txn(2'b00, 0, 2, 1'b1);
    do_txn(2'b11, 0, 1, 1'b1);
    do_txn(2'b00, 0, 3, 1'b1);

    // Single write to device 0x4C.
    m_rnw[0] = 1'b0; m_dev[0] = 7'h4C; m_reg[0] = 8'h0A; m_wd[0] = 8'h55;
    use_dir = 1'b1; dir_e = 1'b0; dir_rd = 8'h00;
    do_txn(2'b01, 0, 3, 1'b0);

    // Read by requester 1 returning 0xA7.
    m_rnw[1] = 1'b1; m_dev[1] = 7'h2D; m_reg[1] = 8'h33; m_wd[1] = 8'h00;
    dir_e = 1'b0; dir_rd = 8'hA7;
    do_txn(2'b10, 0, 6, 1'b0);
    use_dir = 1'b0;

    do_txn(2'b01, 1, 0, 1'b1);   // timeout
    do_txn(2'b10, 0, T, 1'b1);   // eng_done collides with timeout
    do_txn(2'b01, 3, 5, 1'b1);   // reset during WAIT
    do_txn(2'b11, 0, 2, 1'b1);   // fresh arbitration: requester 0 wins

    for (int i = 0; i < 25; i++) begin
      nr = 2'($urandom_range(0, 3));
      if ((nr | pend) == 2'b00) nr = 2'b01;
      sel = $urandom_range(0, 19);
      if (sel == 0) begin
        mode = 1; d = 0;
      end else if (sel == 1) begin
        mode = 0; d = T;
      end else begin
        mode = 0; d = $urandom_range(1, 15);
      end
      do_txn(nr, mode, d, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
